// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte to the device over
// the shared open-drain PS2_CLK / PS2_DATA pair: inhibit the clock, request to
// send (start bit), shift 8 data bits + odd parity + stop on the device's
// falling clock edges, then sample the device ACK on the following edge.
// The block never drives a line high; *_oe = 1 pulls the pad low.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous, active-low reset
//   tx_data      in   [7:0] command byte, captured on accept
//   tx_valid     in   transfer request; accepted when tx_valid && tx_ready
//   tx_ready     out  high only while idle
//   ps2_clk_in   in   PS2_CLK pad level (asynchronous)
//   ps2_data_in  in   PS2_DATA pad level (asynchronous)
//   ps2_clk_oe   out  1 = pull PS2_CLK low
//   ps2_data_oe  out  1 = pull PS2_DATA low
//   busy         out  transfer in progress (receiver must ignore the bus)
//   done         out  one-cycle pulse at the end of every accepted transfer
//   ack_err      out  device did not ACK; held until the next accept
//   timeout_err  out  device clock timeout; held until the next accept
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_CYCLES   = 250,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    // ------------------------------------------------------------------
    // Counter widths. Each counter only has to reach (N-1), so $clog2(N)
    // bits suffice; a minimum of one bit keeps degenerate settings legal.
    // ------------------------------------------------------------------
    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int STA_W = (START_CYCLES   > 1) ? $clog2(START_CYCLES)   : 1;
    localparam int PH_W  = (INH_W > STA_W) ? INH_W : STA_W;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int FL_W  = (FILTER_CYCLES  > 1) ? $clog2(FILTER_CYCLES)  : 1;

    localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
    localparam logic [PH_W-1:0] STA_LAST = PH_W'(START_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FL_W-1:0] FL_LAST  = FL_W'(FILTER_CYCLES - 1);
    localparam logic [3:0]      BIT_LAST = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    // ------------------------------------------------------------------
    // Pad conditioning: 2-FF synchronizer followed by a level filter.
    // Index 0 = PS2_CLK, index 1 = PS2_DATA. Everything resets to the
    // released (high) level so no edge is seen coming out of reset.
    // ------------------------------------------------------------------
    logic [1:0] pad_raw;
    logic [1:0] pad_filt;

    assign pad_raw = {ps2_data_in, ps2_clk_in};

    for (genvar gi = 0; gi < 2; gi++) begin : g_pad
        logic            sync1_reg;
        logic            sync2_reg;
        logic            filt_reg;
        logic [FL_W-1:0] filt_cnt_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_reg    <= 1'b1;
                sync2_reg    <= 1'b1;
                filt_reg     <= 1'b1;
                filt_cnt_reg <= '0;
            end else begin
                sync1_reg <= pad_raw[gi];
                sync2_reg <= sync1_reg;
                // The accepted level moves only once the synced value has
                // disagreed with it for FILTER_CYCLES cycles in a row; any
                // agreeing cycle restarts the run.
                if (sync2_reg == filt_reg) begin
                    filt_cnt_reg <= '0;
                end else if (filt_cnt_reg == FL_LAST) begin
                    filt_reg     <= sync2_reg;
                    filt_cnt_reg <= '0;
                end else begin
                    filt_cnt_reg <= filt_cnt_reg + 1'b1;
                end
            end
        end

        assign pad_filt[gi] = filt_reg;
    end

    logic clk_filt;
    logic data_filt;
    logic clk_filt_d_reg;
    logic clk_fall;
    logic clk_edge;

    assign clk_filt  = pad_filt[0];
    assign data_filt = pad_filt[1];
    assign clk_fall  = clk_filt_d_reg & ~clk_filt;
    assign clk_edge  = clk_filt_d_reg ^ clk_filt;

    // ------------------------------------------------------------------
    // Transfer state
    // ------------------------------------------------------------------
    state_t          state_reg,    state_next;
    logic [PH_W-1:0] ph_cnt_reg,   ph_cnt_next;
    logic [TO_W-1:0] to_cnt_reg,   to_cnt_next;
    logic [3:0]      bit_cnt_reg,  bit_cnt_next;
    logic [9:0]      frame_reg,    frame_next;
    logic            drive_reg,    drive_next;
    logic            ack_err_reg,  ack_err_next;
    logic            to_err_reg,   to_err_next;
    logic            done_pulse;
    logic            watch_clk;
    logic            timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            ph_cnt_reg     <= '0;
            to_cnt_reg     <= '0;
            bit_cnt_reg    <= '0;
            frame_reg      <= '0;
            drive_reg      <= 1'b0;
            ack_err_reg    <= 1'b0;
            to_err_reg     <= 1'b0;
            clk_filt_d_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            ph_cnt_reg     <= ph_cnt_next;
            to_cnt_reg     <= to_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            frame_reg      <= frame_next;
            drive_reg      <= drive_next;
            ack_err_reg    <= ack_err_next;
            to_err_reg     <= to_err_next;
            clk_filt_d_reg <= clk_filt;
        end
    end

    // Device clock is only supervised once the host has let go of PS2_CLK.
    assign watch_clk   = (state_reg == SHIFT) || (state_reg == ACK) ||
                         (state_reg == WAIT_IDLE);
    assign timeout_hit = watch_clk && (to_cnt_reg == TO_LAST);

    always_comb begin
        state_next   = state_reg;
        ph_cnt_next  = ph_cnt_reg;
        to_cnt_next  = '0;
        bit_cnt_next = bit_cnt_reg;
        frame_next   = frame_reg;
        drive_next   = drive_reg;
        ack_err_next = ack_err_reg;
        to_err_next  = to_err_reg;
        done_pulse   = 1'b0;

        // Timeout counter: restarts on any filtered clock edge, saturates.
        if (watch_clk) begin
            if (clk_edge) begin
                to_cnt_next = '0;
            end else if (to_cnt_reg != TO_LAST) begin
                to_cnt_next = to_cnt_reg + 1'b1;
            end else begin
                to_cnt_next = to_cnt_reg;
            end
        end

        case (state_reg)
            IDLE: begin
                if (tx_valid) begin
                    // {stop, odd parity, data}; bit n is sent on edge n.
                    frame_next   = {1'b1, ~^tx_data, tx_data};
                    ack_err_next = 1'b0;
                    to_err_next  = 1'b0;
                    ph_cnt_next  = '0;
                    state_next   = INHIBIT;
                end
            end

            INHIBIT: begin
                if (ph_cnt_reg == INH_LAST) begin
                    ph_cnt_next = '0;
                    state_next  = START;
                end else begin
                    ph_cnt_next = ph_cnt_reg + 1'b1;
                end
            end

            START: begin
                if (ph_cnt_reg == STA_LAST) begin
                    ph_cnt_next  = '0;
                    bit_cnt_next = '0;
                    drive_next   = 1'b1;   // keep the start bit on the line
                    state_next   = SHIFT;
                end else begin
                    ph_cnt_next = ph_cnt_reg + 1'b1;
                end
            end

            SHIFT: begin
                if (clk_fall) begin
                    // frame_reg[9] is the stop bit (1), so edge 9 releases DATA.
                    drive_next = ~frame_reg[bit_cnt_reg];
                    if (bit_cnt_reg == BIT_LAST) begin
                        state_next = ACK;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end

            ACK: begin
                if (clk_fall) begin
                    ack_err_next = data_filt;
                    state_next   = WAIT_IDLE;
                end
            end

            WAIT_IDLE: begin
                if (clk_filt && data_filt) begin
                    done_pulse = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // A stalled device overrides whatever edge arrived in the same cycle.
        if (timeout_hit) begin
            state_next   = IDLE;
            bit_cnt_next = bit_cnt_reg;
            ack_err_next = ack_err_reg;
            drive_next   = 1'b0;
            to_err_next  = 1'b1;
            done_pulse   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs are decoded from registered state so the async reset
    // releases both lines immediately.
    // ------------------------------------------------------------------
    assign tx_ready    = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign ps2_clk_oe  = (state_reg == INHIBIT) || (state_reg == START);
    assign ps2_data_oe = (state_reg == START) || ((state_reg == SHIFT) && drive_reg);
    assign done        = done_pulse;
    assign ack_err     = ack_err_reg;
    assign timeout_err = to_err_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Bench for ps2_host_tx with shortened timing parameters. A device model
// produces the PS/2 clock, reads the frame on its rising edges and optionally
// ACKs. A per-cycle compare process holds a cycle-count model of the request
// phase and of the handshake/status outputs.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int INH  = 40;
    localparam int STC  = 10;
    localparam int TMO  = 600;
    localparam int FLT  = 8;
    localparam int HALF = 40;     // device clock half period in system cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    always #5 clk = ~clk;

    // Open-drain wired-AND of device and host.
    assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_CYCLES  (STC),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_CYCLES (FLT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Model: after an accept the clock is held low for INH+STC cycles, the
    // data line joins for the last STC of them and stays low one more cycle.
    // Status flags follow the planned outcome of the transfer.
    // ------------------------------------------------------------------
    bit m_busy   = 1'b0;
    int m_k      = 0;
    bit exp_ack  = 1'b0;
    bit exp_to   = 1'b0;
    bit plan_ack = 1'b0;
    bit plan_to  = 1'b0;
    int done_cnt = 0;
    int acc_cnt  = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            exp_ack = 1'b0;
            exp_to  = 1'b0;
            chk("rst_tx_ready", tx_ready, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_clk_oe", ps2_clk_oe, 1'b0);
            chk("rst_data_oe", ps2_data_oe, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_ack_err", ack_err, 1'b0);
            chk("rst_timeout_err", timeout_err, 1'b0);
        end else if (m_busy) begin
            m_k++;
            chk("busy", busy, 1'b1);
            chk("tx_ready_busy", tx_ready, 1'b0);
            chk("timeout_err_busy", timeout_err, 1'b0);
            if (m_k <= INH + STC + 1) begin
                chk("clk_oe_req", ps2_clk_oe, (m_k <= INH + STC));
                chk("data_oe_req", ps2_data_oe, (m_k > INH));
            end
            if (done === 1'b1) begin
                done_cnt++;
                chk("ack_err_at_done", ack_err, exp_ack);
                m_busy = 1'b0;
            end
        end else begin
            chk("idle_busy", busy, 1'b0);
            chk("idle_tx_ready", tx_ready, 1'b1);
            chk("idle_done", done, 1'b0);
            chk("idle_clk_oe", ps2_clk_oe, 1'b0);
            chk("idle_data_oe", ps2_data_oe, 1'b0);
            chk("idle_ack_err", ack_err, exp_ack);
            chk("idle_timeout_err", timeout_err, exp_to);
            if (tx_valid) begin
                m_busy  = 1'b1;
                m_k     = 0;
                exp_ack = plan_ack;
                exp_to  = plan_to;
                acc_cnt++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Device model. Drives n_edges clock pulses, reads host bits on rising
    // edges (bits 0..9 = data, parity, stop), optional ACK on edge 10 and an
    // optional 3-cycle clock glitch in the high phase after edge 4.
    // ------------------------------------------------------------------
    task automatic dev_xfer(input int n_edges, input bit ack_low, input bit glitch,
                            output logic [9:0] got);
        int w;
        got = '0;
        w = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1)) begin
            cyc();
            w++;
            if (w > 2000) begin
                n_checks++;
                n_fail++;
                $display("FAIL rts_wait: no request-to-send after %0d cycles", w);
                return;
            end
        end
        chk("start_bit_line", ps2_data_in, 1'b0);
        repeat (30) cyc();
        for (int e = 0; e < n_edges; e++) begin
            dev_clk = 1'b0;
            repeat (HALF) cyc();
            dev_clk = 1'b1;
            if (e < 10) got[e] = ps2_data_in;
            if (glitch && e == 4) begin
                repeat (10) cyc();
                dev_clk = 1'b0;
                repeat (3) cyc();
                dev_clk = 1'b1;
                repeat (HALF - 13) cyc();
            end else if (e == 9 && ack_low) begin
                repeat (HALF / 2) cyc();
                dev_data = 1'b0;
                repeat (HALF / 2) cyc();
            end else begin
                repeat (HALF) cyc();
            end
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_done(input int snap, input int budget, output int cycles);
        cycles = 0;
        while (done_cnt == snap) begin
            cyc();
            cycles++;
            if (cycles > budget) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_wait: no done within %0d cycles", budget);
                return;
            end
        end
    endtask

    // Full transfer: request, device exchange, wait for completion.
    task automatic do_xfer(input logic [7:0] b, input bit ack_low, input bit glitch,
                           input bit hold, output logic [9:0] got);
        int snap;
        int cycles;
        int acc0;
        snap     = done_cnt;
        acc0     = acc_cnt;
        plan_ack = !ack_low;
        plan_to  = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        cyc();
        if (!hold) tx_valid = 1'b0;
        dev_xfer(11, ack_low, glitch, got);
        wait_done(snap, 2000, cycles);
        tx_valid = 1'b0;
        cyc();
        chk("single_accept", (acc_cnt == acc0 + 1), 1'b1);
        chk8("dev_data", got[7:0], b);
        chk("dev_parity", got[8], ($countones(b) % 2 == 0));
        chk("dev_stop", got[9], 1'b1);
        chk("ack_err_after", ack_err, !ack_low);
        chk("timeout_err_after", timeout_err, 1'b0);
        $display("xfer %02h: device read data=%02h parity=%b stop=%b ack_err=%b",
                 b, got[7:0], got[8], got[9], ack_err);
    endtask

    logic [9:0] got;
    int         snap;
    int         cycles;

    initial begin
        repeat (4) cyc();
        rst_n = 1'b1;
        repeat (4) cyc();

        // 0xED: six ones -> odd parity bit 1; device ACKs.
        do_xfer(8'hED, 1'b1, 1'b0, 1'b0, got);
        chk("ed_parity_literal", got[8], 1'b1);

        // 0x00: parity 1, device never ACKs.
        do_xfer(8'h00, 1'b0, 1'b0, 1'b0, got);
        chk("zero_parity_literal", got[8], 1'b1);

        // Device stalls after edge 3.
        snap     = done_cnt;
        plan_ack = 1'b0;
        plan_to  = 1'b1;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        cyc();
        tx_valid = 1'b0;
        dev_xfer(4, 1'b0, 1'b0, got);
        chk8("to_bits", {4'h0, got[3:0]}, 8'h0F);
        wait_done(snap, TMO + 200, cycles);
        cyc();
        chk("to_latency", ((HALF + cycles) >= TMO) && ((HALF + cycles) <= TMO + FLT + 8), 1'b1);
        chk("to_err_set", timeout_err, 1'b1);
        chk("to_clk_released", ps2_clk_oe, 1'b0);
        chk("to_data_released", ps2_data_oe, 1'b0);
        $display("timeout: done %0d cycles after last device edge, timeout_err=%b",
                 HALF + cycles, timeout_err);

        // Next request clears timeout_err; 0x01 has odd parity bit 0.
        do_xfer(8'h01, 1'b1, 1'b0, 1'b0, got);
        chk("one_parity_literal", got[8], 1'b0);

        // Clock glitch during SHIFT and tx_valid held for the whole transfer.
        do_xfer(8'hA5, 1'b1, 1'b1, 1'b1, got);

        // Reset in the middle of SHIFT (after edge 4 of 0xE5, bit 4 = 0).
        plan_ack = 1'b0;
        plan_to  = 1'b0;
        tx_data  = 8'hE5;
        tx_valid = 1'b1;
        cyc();
        tx_valid = 1'b0;
        dev_xfer(5, 1'b0, 1'b0, got);
        chk("pre_rst_data_oe", ps2_data_oe, 1'b1);
        chk("pre_rst_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_clk_oe", ps2_clk_oe, 1'b0);
        chk("midrst_data_oe", ps2_data_oe, 1'b0);
        chk("midrst_tx_ready", tx_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        $display("reset mid-shift: clk_oe=%b data_oe=%b tx_ready=%b",
                 ps2_clk_oe, ps2_data_oe, tx_ready);
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (4) cyc();

        // Normal operation resumes after reset.
        do_xfer(8'h3C, 1'b1, 1'b0, 1'b0, got);

        repeat (5) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
